// File: rtl/sort_pkg.sv
// Shared constants, state encoding and byte helpers for the sort frame client.
package sort_pkg;
    localparam int SORT_VALUE_WIDTH = 10;
    localparam int SORT_COUNT_WIDTH = 16;
    localparam int BYTES_PER_VALUE  = 2;
    localparam int WIRE_WIDTH       = 8 * BYTES_PER_VALUE;

    typedef enum logic [2:0] {
        IDLE,
        TX_CNT_HI,
        TX_CNT_LO,
        TX_VAL_HI,
        TX_VAL_LO,
        RX_HI,
        RX_LO,
        RES_OUT
    } sort_state_e;

    function automatic logic [7:0] hi_byte(input logic [WIRE_WIDTH-1:0] w);
        return w[WIRE_WIDTH-1 -: 8];
    endfunction

    function automatic logic [7:0] lo_byte(input logic [WIRE_WIDTH-1:0] w);
        return w[7:0];
    endfunction
endpackage

// File: rtl/sort_order_checker.sv
// Sticky monotonic-order checker over a frame's result stream; cleared per frame.
module sort_order_checker
    import sort_pkg::*;
#(
    parameter int VALUE_WIDTH = SORT_VALUE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   fire,
    input  logic [VALUE_WIDTH-1:0] value,
    output logic                   err
);
    logic [VALUE_WIDTH-1:0] prev;
    logic                   first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= '0;
            first <= 1'b1;
            err   <= 1'b0;
        end else if (clear) begin
            first <= 1'b1;
            err   <= 1'b0;
        end else if (fire) begin
            // The first result of a frame has no predecessor to compare with.
            if (!first && (value < prev))
                err <= 1'b1;
            prev  <= value;
            first <= 1'b0;
        end
    end
endmodule

// File: rtl/sort_frame_client.sv
// Sends a frame of values to a UART sorter and reassembles the sorted reply.
// Optional order checking is compiled in with SORT_CLIENT_ORDER_CHECK_EN.
module sort_frame_client
    import sort_pkg::*;
#(
    parameter int VALUE_WIDTH = SORT_VALUE_WIDTH,
    parameter int COUNT_WIDTH = SORT_COUNT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    input  logic [VALUE_WIDTH-1:0] val_data_i,
    input  logic                   val_valid_i,
    output logic                   val_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [VALUE_WIDTH-1:0] res_data_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   order_err_o
);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    sort_state_e            state;
    logic [COUNT_WIDTH-1:0] cnt, rem;
    logic [7:0]             rx_hi, val_lo;
    logic                   start_acc, tx_fire, val_fire, rx_fire, res_fire, last;

    // A start landing on the done cycle belongs to the finished frame and is dropped.
    assign start_acc = (state == IDLE) && start_i && !done_o;
    assign tx_fire   = tx_valid_o && tx_ready_i;
    assign val_fire  = val_valid_i && val_ready_o;
    assign rx_fire   = rx_valid_i && rx_ready_o;
    assign res_fire  = res_valid_o && res_ready_i;
    assign last      = (rem == ONE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            rx_hi       <= '0;
            val_lo      <= '0;
            tx_valid_o  <= 1'b0;
            tx_data_o   <= '0;
            val_ready_o <= 1'b0;
            rx_ready_o  <= 1'b0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (start_acc) begin
                    cnt        <= count_i;
                    rem        <= '0;
                    busy_o     <= 1'b1;
                    tx_valid_o <= 1'b1;
                    tx_data_o  <= hi_byte(WIRE_WIDTH'(count_i));
                    state      <= TX_CNT_HI;
                end
                TX_CNT_HI: if (tx_fire) begin
                    tx_data_o <= lo_byte(WIRE_WIDTH'(cnt));
                    state     <= TX_CNT_LO;
                end
                TX_CNT_LO: if (tx_fire) begin
                    tx_valid_o <= 1'b0;
                    if (cnt == '0) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        rem         <= cnt;
                        val_ready_o <= 1'b1;
                        state       <= TX_VAL_HI;
                    end
                end
                // Stays here while the value is held and its high byte is offered.
                TX_VAL_HI: if (val_fire) begin
                    val_ready_o <= 1'b0;
                    tx_valid_o  <= 1'b1;
                    tx_data_o   <= hi_byte(WIRE_WIDTH'(val_data_i));
                    val_lo      <= lo_byte(WIRE_WIDTH'(val_data_i));
                end else if (tx_fire) begin
                    tx_data_o <= val_lo;
                    state     <= TX_VAL_LO;
                end
                TX_VAL_LO: if (tx_fire) begin
                    tx_valid_o <= 1'b0;
                    if (last) begin
                        rem        <= cnt;
                        rx_ready_o <= 1'b1;
                        state      <= RX_HI;
                    end else begin
                        rem         <= rem - ONE;
                        val_ready_o <= 1'b1;
                        state       <= TX_VAL_HI;
                    end
                end
                RX_HI: if (rx_fire) begin
                    rx_hi <= rx_data_i;
                    state <= RX_LO;
                end
                RX_LO: if (rx_fire) begin
                    res_data_o  <= VALUE_WIDTH'({rx_hi, rx_data_i});
                    res_valid_o <= 1'b1;
                    rx_ready_o  <= 1'b0;
                    state       <= RES_OUT;
                end
                RES_OUT: if (res_fire) begin
                    res_valid_o <= 1'b0;
                    if (last) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        rem        <= rem - ONE;
                        rx_ready_o <= 1'b1;
                        state      <= RX_HI;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SORT_CLIENT_ORDER_CHECK_EN
    sort_order_checker #(.VALUE_WIDTH(VALUE_WIDTH)) u_order (
        .clk   (clk_i),
        .rst   (reset_i),
        .clear (start_acc),
        .fire  (res_fire),
        .value (res_data_o),
        .err   (order_err_o)
    );
`else
    assign order_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sort_frame_client.sv
// Directed bench for sort_frame_client: drives all four streams and checks frames.
module tb_sort_frame_client;
    localparam int VW = 10;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [CW-1:0] count_i;
    logic [VW-1:0] val_data_i;
    logic          val_valid_i, val_ready_o;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o, tx_ready_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i, rx_ready_o;
    logic [VW-1:0] res_data_o;
    logic          res_valid_o, res_ready_i;
    logic          busy_o, done_o, order_err_o;

    sort_frame_client #(.VALUE_WIDTH(VW), .COUNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .count_i(count_i),
        .val_data_i(val_data_i), .val_valid_i(val_valid_i), .val_ready_o(val_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .res_data_o(res_data_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .busy_o(busy_o), .done_o(done_o), .order_err_o(order_err_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] src_q[$], rsp_q[$], tx_got[$], res_got[$], exp_tx[$], exp_res[$];
    bit          stall_en = 0, poke_en = 0, rx_seen = 0;
    int          stop_rx = 0, cyc = 0, last_tx_cyc = 0, done_cyc = 0, exp_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({tx_valid_o, val_ready_o, rx_ready_o, res_valid_o, busy_o, done_o,
                    order_err_o, tx_data_o, res_data_o});
    endfunction

    task automatic start_frame(input logic [CW-1:0] n);
        @(negedge clk_i);
        count_i = n;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i     = poke_en;
        count_i     = 16'h0007;
        tx_ready_i  = 1'b0;
        res_ready_i = 1'b0;
        val_valid_i = 1'b0;
        rx_valid_i  = 1'b0;
        check("start_busy", 32'(busy_o), 1);
        check("start_err_clr", 32'(order_err_o), 0);
    endtask

    // One negedge per iteration: check held data, drive inputs, log transfers.
    task automatic run_frame(input int budget);
        int          n_rx = 0, ts = 0, rs = 0;
        bit          tx_hold = 0, res_hold = 0, fin = 0;
        logic [7:0]  tx_prev = '0;
        logic [VW-1:0] res_prev = '0;
        tx_got.delete();
        res_got.delete();
        rx_seen = 0;
        last_tx_cyc = -1;
        done_cyc = -1;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk_i);
            cyc++;
            if (tx_hold)  check("tx_stall_hold", 32'({tx_valid_o, tx_data_o}), 32'({1'b1, tx_prev}));
            if (res_hold) check("res_stall_hold", 32'({res_valid_o, res_data_o}), 32'({1'b1, res_prev}));
            if (rx_ready_o) rx_seen = 1;
            if (stall_en && ts == 0 && $urandom_range(0, 2) == 0) ts = int'($urandom_range(1, 5));
            if (stall_en && rs == 0 && $urandom_range(0, 2) == 0) rs = int'($urandom_range(1, 5));
            tx_ready_i  = (ts == 0);
            res_ready_i = (rs == 0);
            if (ts > 0) ts--;
            if (rs > 0) rs--;
            start_i     = poke_en;
            val_valid_i = (src_q.size() != 0);
            val_data_i  = val_valid_i ? VW'(src_q[0]) : '0;
            rx_valid_i  = (rsp_q.size() != 0);
            rx_data_i   = rx_valid_i ? 8'(rsp_q[0]) : 8'h00;
            if (tx_valid_o && tx_ready_i) begin
                tx_got.push_back(32'(tx_data_o));
                last_tx_cyc = cyc;
            end
            if (val_valid_i && val_ready_o) void'(src_q.pop_front());
            if (rx_valid_i && rx_ready_o) begin
                void'(rsp_q.pop_front());
                n_rx++;
            end
            if (res_valid_o && res_ready_i) res_got.push_back(32'(res_data_o));
            tx_hold  = tx_valid_o && !tx_ready_i;
            tx_prev  = tx_data_o;
            res_hold = res_valid_o && !res_ready_i;
            res_prev = res_data_o;
            if (done_o) begin
                done_cyc = cyc;
                fin = 1;
            end
            if (stop_rx != 0 && n_rx == stop_rx) fin = 1;
        end
        check("frame_end_reached", 32'(fin), 1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_ntx"}, tx_got.size(), exp_tx.size());
        foreach (exp_tx[i]) if (i < tx_got.size()) check({tag, "_tx"}, tx_got[i], exp_tx[i]);
        check({tag, "_nres"}, res_got.size(), exp_res.size());
        foreach (exp_res[i]) if (i < res_got.size()) check({tag, "_res"}, res_got[i], exp_res[i]);
    endtask

    task automatic post_done(input string tag);
        @(negedge clk_i);
        start_i = 1'b0;
        check({tag, "_done_pulse"}, 32'(done_o), 0);
        check({tag, "_idle_busy"}, 32'(busy_o), 0);
        check({tag, "_idle_txv"}, 32'(tx_valid_o), 0);
    endtask

    initial begin
`ifdef SORT_CLIENT_ORDER_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        reset_i = 1'b1;
        start_i = 1'b0; count_i = '0;
        val_data_i = '0; val_valid_i = 1'b0; tx_ready_i = 1'b0;
        rx_data_i = '0; rx_valid_i = 1'b0; res_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset_outs", outs(), 0);
        reset_i = 1'b0;

        // Basic frame: 5,1,3 sorted to 1,3,5.
        src_q = '{32'h005, 32'h001, 32'h003};
        rsp_q = '{32'h00, 32'h01, 32'h00, 32'h03, 32'h00, 32'h05};
        exp_tx  = '{32'h00, 32'h03, 32'h00, 32'h05, 32'h00, 32'h01, 32'h00, 32'h03};
        exp_res = '{32'h001, 32'h003, 32'h005};
        start_frame(16'd3);
        run_frame(300);
        check("t1_done", 32'(done_o), 1);
        check("t1_err", 32'(order_err_o), 0);
        check_frame("t1");
        post_done("t1");

        // Empty frame: two count bytes, done right after, no rx phase.
        exp_tx  = '{32'h00, 32'h00};
        exp_res = {};
        start_frame(16'd0);
        run_frame(100);
        check_frame("t2");
        check("t2_done_lat", done_cyc, last_tx_cyc + 1);
        check("t2_no_rx", 32'(rx_seen), 0);
        post_done("t2");

        // Descending reply trips the order flag.
        src_q = '{32'h002, 32'h3FF};
        rsp_q = '{32'h03, 32'hFF, 32'h00, 32'h02};
        exp_tx  = '{32'h00, 32'h02, 32'h00, 32'h02, 32'h03, 32'hFF};
        exp_res = '{32'h3FF, 32'h002};
        start_frame(16'd2);
        run_frame(300);
        check_frame("t3");
        check("t3_err", 32'(order_err_o), exp_err);
        post_done("t3");
        check("t3_err_sticky", 32'(order_err_o), exp_err);

        // Random tx/res back-pressure; start_frame also checks the flag clears.
        stall_en = 1;
        src_q = '{32'h123, 32'h045, 32'h3FE, 32'h000};
        rsp_q = '{32'h00, 32'h00, 32'h00, 32'h45, 32'h01, 32'h23, 32'h03, 32'hFE};
        exp_tx  = '{32'h00, 32'h04, 32'h01, 32'h23, 32'h00, 32'h45, 32'h03, 32'hFE, 32'h00, 32'h00};
        exp_res = '{32'h000, 32'h045, 32'h123, 32'h3FE};
        start_frame(16'd4);
        run_frame(1000);
        check_frame("t4");
        check("t4_err", 32'(order_err_o), 0);
        post_done("t4");
        stall_en = 0;

        // start_i held high through busy and the done cycle; upper rx bits dropped.
        poke_en = 1;
        src_q = '{32'h2A5};
        rsp_q = '{32'hFE, 32'hA5};
        exp_tx  = '{32'h00, 32'h01, 32'h02, 32'hA5};
        exp_res = '{32'h2A5};
        start_frame(16'd1);
        run_frame(200);
        check_frame("t5");
        poke_en = 0;
        post_done("t5");
        repeat (3) @(negedge clk_i);
        check("t5_no_extra_busy", 32'(busy_o), 0);
        check("t5_no_extra_tx", 32'(tx_valid_o), 0);

        // Reset mid-reply, while the low byte is awaited.
        stop_rx = 1;
        src_q = '{32'h0AB};
        rsp_q = '{32'h00};
        start_frame(16'd1);
        run_frame(200);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        check("t6_in_rx_lo", 32'({busy_o, rx_ready_o}), 32'h3);
        #1 reset_i = 1'b1;
        #1 check("t6_reset_outs", outs(), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        stop_rx = 0;

        src_q = '{32'h155};
        rsp_q = '{32'h01, 32'h55};
        exp_tx  = '{32'h00, 32'h01, 32'h01, 32'h55};
        exp_res = '{32'h155};
        start_frame(16'd1);
        run_frame(200);
        check("t7_done", 32'(done_o), 1);
        check_frame("t7");
        post_done("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sort_frame_client.md
SORT_FRAME_CLIENT -- requirements
Module: sort_frame_client

Interface
REQ-001 Parameter VALUE_WIDTH, default 10, bit width of one sort value (SHALL be 1..16).
REQ-002 Parameter COUNT_WIDTH, default 16, bit width of the frame value count.
REQ-003 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  request to send one frame; sampled only in IDLE.
REQ-006 count_i  input  COUNT_WIDTH  number of values in the frame; latched on accepted start.
REQ-007 val_data_i / val_valid_i / val_ready_o  in/in/out  VALUE_WIDTH/1/1  unsorted value stream from local source.
REQ-008 tx_data_o / tx_valid_o / tx_ready_i  out/out/in  8/1/1  byte stream to UART transmitter.
REQ-009 rx_data_i / rx_valid_i / rx_ready_o  in/in/out  8/1/1  byte stream from UART receiver.
REQ-010 res_data_o / res_valid_o / res_ready_i  out/out/in  VALUE_WIDTH/1/1  reassembled sorted results.
REQ-011 busy_o  output  1  high from accepted start until done.
REQ-012 done_o  output  1  one-cycle pulse at frame completion.
REQ-013 order_err_o  output  1  sticky flag: a result was smaller than its predecessor.

Function
REQ-014 All streams SHALL use valid/ready; a transfer occurs on a cycle with valid and ready both high; valid, once asserted, SHALL hold with stable data until the transfer.
REQ-015 Wire frame (host to sorter): count high byte, count low byte, then per value high byte then low byte; value right-justified in 16 bits, unused upper bits zero.
REQ-016 Response frame (sorter to host): exactly count values, two bytes each, high byte first; upper bits beyond VALUE_WIDTH SHALL be discarded.
REQ-017 States: IDLE, TX_CNT_HI, TX_CNT_LO, TX_VAL_HI, TX_VAL_LO, RX_HI, RX_LO, RES_OUT.
REQ-018 IDLE with start_i high: latch count_i, clear order_err_o and remaining counter, go to TX_CNT_HI next cycle; busy_o high from that cycle.
REQ-019 TX_CNT_HI/TX_CNT_LO: tx_valid_o high with the respective count byte; advance on transfer.
REQ-020 After TX_CNT_LO with count zero: return to IDLE and pulse done_o on the cycle after the low-byte transfer; no rx phase.
REQ-021 TX_VAL_HI: val_ready_o high until a value is accepted; value SHALL be registered and its high byte driven in the following cycle; tx_valid_o SHALL NOT be asserted before a value is held.
REQ-022 TX_VAL_LO: send low byte; on transfer decrement remaining; at zero go to RX_HI with remaining reloaded to count, else TX_VAL_HI.
REQ-023 rx_ready_o SHALL be high only in RX_HI and RX_LO; bytes arriving in other states are not consumed.
REQ-024 RX_HI stores the high byte; RX_LO forms the value and enters RES_OUT.
REQ-025 RES_OUT: res_valid_o high until res_ready_i; on transfer decrement remaining; at zero pulse done_o, clear busy_o, go to IDLE, else RX_HI.
REQ-026 Order check: each result after the first of a frame compared unsigned to the previous one; if smaller, order_err_o SHALL set at the res transfer and hold until the next accepted start or reset.
REQ-027 start_i while busy SHALL be ignored; a start in the same cycle as done_o SHALL be ignored.
REQ-028 Count value 2^COUNT_WIDTH-1 SHALL be handled without counter overflow.

Reset
REQ-029 reset_i asserted at any time SHALL asynchronously force IDLE and drive every output (tx_valid_o, val_ready_o, rx_ready_o, res_valid_o, res_data_o, tx_data_o, busy_o, done_o, order_err_o) to zero; a partial frame is abandoned.

Configuration
REQ-030 Macro SORT_CLIENT_ORDER_CHECK_EN defined: REQ-026 checker compiled in.
REQ-031 Macro undefined: checker logic absent, order_err_o tied to zero; all other behaviour identical.

Structure
REQ-032 Shared package sort_pkg SHALL hold default VALUE_WIDTH/COUNT_WIDTH constants, the state enum type and the bytes-per-value constant (2).
REQ-033 The order checker SHALL be sub-module sort_order_checker, instantiated only under SORT_CLIENT_ORDER_CHECK_EN.

Verification
REQ-034 count=3, values 5,1,3 -> tx bytes 00 03 00 05 00 01 00 03; rx 00 01 00 03 00 05 -> results 1,3,5, done_o pulse, order_err_o=0.
REQ-035 count=0 -> tx bytes 00 00 only, done_o one cycle after second byte, rx_ready_o never high.
REQ-036 count=2, response values 0x3FF then 0x002 -> order_err_o=1 after second result, cleared by next start.
REQ-037 tx_ready_i and res_ready_i randomly deasserted for 1-5 cycles -> bytes/values unchanged while stalled, no loss or duplication.
REQ-038 reset_i asserted during RX_LO -> all outputs zero same cycle; new start with count=1 completes normally.
REQ-039 start_i pulsed during busy and in done_o cycle -> ignored, no extra frame transmitted.
